// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin APB arbiter: the grant is held for one complete SETUP/ACCESS transfer.
// Optional macro ARB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module apb_rr_arbiter #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 16,
    parameter int STRB_W         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel_m0,
    input  logic              psel_m1,
    input  logic              penable_m0,
    input  logic              penable_m1,
    input  logic              pwrite_m0,
    input  logic              pwrite_m1,
    input  logic [STRB_W-1:0] pstrb_m0,
    input  logic [STRB_W-1:0] pstrb_m1,
    input  logic [ADDR_W-1:0] paddr_m0,
    input  logic [ADDR_W-1:0] paddr_m1,
    input  logic [DATA_W-1:0] pwdata_m0,
    input  logic [DATA_W-1:0] pwdata_m1,
    output logic [DATA_W-1:0] prdata_m0,
    output logic [DATA_W-1:0] prdata_m1,
    output logic              pready_m0,
    output logic              pready_m1,
    output logic              pslverr_m0,
    output logic              pslverr_m1,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [STRB_W-1:0] pstrb,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t r_state, w_state_nxt;

    // Handshake: a requester holds psel_mX until it sees a one-cycle pready_mX; downstream
    // completes an ACCESS cycle only when pready is high while psel and penable are both high.
    logic              r_last;   // 1 when m1 held the most recent grant
    logic              r_psel, r_penable, r_pwrite;
    logic [STRB_W-1:0] r_pstrb;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [1:0]        r_gnt;
    logic              r_pready_m0, r_pready_m1, r_pslverr_m0, r_pslverr_m1;
    logic [DATA_W-1:0] r_prdata_m0, r_prdata_m1;

    logic              w_last;
    logic              w_psel, w_penable, w_pwrite;
    logic [STRB_W-1:0] w_pstrb;
    logic [ADDR_W-1:0] w_paddr;
    logic [DATA_W-1:0] w_pwdata;
    logic [1:0]        w_gnt;
    logic              w_pready_m0, w_pready_m1, w_pslverr_m0, w_pslverr_m1;
    logic [DATA_W-1:0] w_prdata_m0, w_prdata_m1;
    logic              w_win;
    logic              w_abort;
    logic              w_unused;

    // Winner: 1 selects m1; on contention the requester not granted last wins.
    assign w_win    = (psel_m0 & psel_m1) ? ~r_last : psel_m1;
    assign w_unused = &{1'b0, penable_m0, penable_m1};

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !pready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Expiry is the wait cycle that brings the count to TIMEOUT_CYCLES; a same-cycle pready wins.
    assign w_abort = (r_state == ACCESS) && !pready && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_abort      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last       = r_last;
        w_psel       = r_psel;
        w_penable    = r_penable;
        w_pwrite     = r_pwrite;
        w_pstrb      = r_pstrb;
        w_paddr      = r_paddr;
        w_pwdata     = r_pwdata;
        w_gnt        = r_gnt;
        w_pready_m0  = 1'b0;
        w_pready_m1  = 1'b0;
        w_pslverr_m0 = 1'b0;
        w_pslverr_m1 = 1'b0;
        w_prdata_m0  = '0;
        w_prdata_m1  = '0;
        case (r_state)
            IDLE: begin
                if (psel_m0 | psel_m1) begin
                    w_state_nxt = SETUP;
                    w_psel      = 1'b1;
                    w_penable   = 1'b0;
                    w_pwrite    = w_win ? pwrite_m1 : pwrite_m0;
                    w_pstrb     = w_win ? pstrb_m1  : pstrb_m0;
                    w_paddr     = w_win ? paddr_m1  : paddr_m0;
                    w_pwdata    = w_win ? pwdata_m1 : pwdata_m0;
                    w_gnt       = w_win ? 2'b10 : 2'b01;
                    w_last      = w_win;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_penable   = 1'b1;
            end
            ACCESS: begin
                if (pready | w_abort) begin
                    w_state_nxt  = RESP;
                    w_psel       = 1'b0;
                    w_penable    = 1'b0;
                    w_pwrite     = 1'b0;
                    w_pstrb      = '0;
                    w_paddr      = '0;
                    w_pwdata     = '0;
                    w_pready_m0  = r_gnt[0];
                    w_pready_m1  = r_gnt[1];
                    w_prdata_m0  = (r_gnt[0] & pready) ? prdata : '0;
                    w_prdata_m1  = (r_gnt[1] & pready) ? prdata : '0;
                    w_pslverr_m0 = r_gnt[0] & (pready ? pslverr : 1'b1);
                    w_pslverr_m1 = r_gnt[1] & (pready ? pslverr : 1'b1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_gnt       = 2'b00;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last       <= 1'b1;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_pstrb      <= '0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_gnt        <= 2'b00;
            r_pready_m0  <= 1'b0;
            r_pready_m1  <= 1'b0;
            r_pslverr_m0 <= 1'b0;
            r_pslverr_m1 <= 1'b0;
            r_prdata_m0  <= '0;
            r_prdata_m1  <= '0;
        end else begin
            r_last       <= w_last;
            r_psel       <= w_psel;
            r_penable    <= w_penable;
            r_pwrite     <= w_pwrite;
            r_pstrb      <= w_pstrb;
            r_paddr      <= w_paddr;
            r_pwdata     <= w_pwdata;
            r_gnt        <= w_gnt;
            r_pready_m0  <= w_pready_m0;
            r_pready_m1  <= w_pready_m1;
            r_pslverr_m0 <= w_pslverr_m0;
            r_pslverr_m1 <= w_pslverr_m1;
            r_prdata_m0  <= w_prdata_m0;
            r_prdata_m1  <= w_prdata_m1;
        end
    end

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign pstrb      = r_pstrb;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign gnt        = r_gnt;
    assign pready_m0  = r_pready_m0;
    assign pready_m1  = r_pready_m1;
    assign pslverr_m0 = r_pslverr_m0;
    assign pslverr_m1 = r_pslverr_m1;
    assign prdata_m0  = r_prdata_m0;
    assign prdata_m1  = r_prdata_m1;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Build with ARB_TIMEOUT_EN defined to also run the ACCESS-timeout scenario (TIMEOUT_CYCLES=8).
module tb_apb_rr_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int SW = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int TO        = 8;
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam int TO        = 255;
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          psel_m0 = 0, psel_m1 = 0, penable_m0 = 0, penable_m1 = 0;
    logic          pwrite_m0 = 0, pwrite_m1 = 0;
    logic [SW-1:0] pstrb_m0 = '0, pstrb_m1 = '0;
    logic [AW-1:0] paddr_m0 = '0, paddr_m1 = '0;
    logic [DW-1:0] pwdata_m0 = '0, pwdata_m1 = '0;
    logic [DW-1:0] prdata_m0, prdata_m1;
    logic          pready_m0, pready_m1, pslverr_m0, pslverr_m1;
    logic          psel, penable, pwrite;
    logic [SW-1:0] pstrb;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [1:0]    gnt;

    apb_rr_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .psel_m0(psel_m0), .psel_m1(psel_m1),
        .penable_m0(penable_m0), .penable_m1(penable_m1),
        .pwrite_m0(pwrite_m0), .pwrite_m1(pwrite_m1),
        .pstrb_m0(pstrb_m0), .pstrb_m1(pstrb_m1),
        .paddr_m0(paddr_m0), .paddr_m1(paddr_m1),
        .pwdata_m0(pwdata_m0), .pwdata_m1(pwdata_m1),
        .prdata_m0(prdata_m0), .prdata_m1(prdata_m1),
        .pready_m0(pready_m0), .pready_m1(pready_m1),
        .pslverr_m0(pslverr_m0), .pslverr_m1(pslverr_m1),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .gnt(gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- downstream completer ----------------
    logic          ds_tie1 = 0, ds_hang = 0, ds_err = 0;
    int            ds_wait = 0, ds_cnt = 0;
    logic [DW-1:0] ds_rdata = '0;

    always @(posedge clk) begin
        #1;
        if (ds_tie1) begin
            pready = 1'b1; prdata = ds_rdata; pslverr = ds_err;
        end else if (psel && penable) begin
            pready  = !ds_hang && (ds_cnt == ds_wait);
            prdata  = pready ? ds_rdata : '0;
            pslverr = pready ? ds_err : 1'b0;
            ds_cnt++;
        end else begin
            pready = 1'b0; prdata = '0; pslverr = 1'b0; ds_cnt = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    int            m_owner = -1;
    int            m_age = 0, m_wait = 0;
    bit            m_resp = 0, m_last = 1;
    logic          e_psel = 0, e_penable = 0, e_pwrite = 0;
    logic [SW-1:0] e_pstrb = '0;
    logic [AW-1:0] e_paddr = '0;
    logic [DW-1:0] e_pwdata = '0, e_prdata0 = '0, e_prdata1 = '0;
    logic [1:0]    e_gnt = '0;
    logic          e_pready0 = 0, e_pready1 = 0, e_err0 = 0, e_err1 = 0;

    task automatic model_clear_bus();
        e_psel = 0; e_penable = 0; e_pwrite = 0; e_pstrb = '0; e_paddr = '0; e_pwdata = '0;
    endtask

    task automatic model_reset();
        model_clear_bus();
        m_owner = -1; m_age = 0; m_wait = 0; m_resp = 0; m_last = 1; e_gnt = '0;
        e_pready0 = 0; e_pready1 = 0; e_err0 = 0; e_err1 = 0; e_prdata0 = '0; e_prdata1 = '0;
    endtask

    task automatic model_finish(input logic [DW-1:0] d, input logic err);
        model_clear_bus();
        if (m_owner == 0) begin e_pready0 = 1; e_prdata0 = d; e_err0 = err; end
        else              begin e_pready1 = 1; e_prdata1 = d; e_err1 = err; end
        m_resp = 1;
    endtask

    task automatic model_step();
        e_pready0 = 0; e_pready1 = 0; e_err0 = 0; e_err1 = 0; e_prdata0 = '0; e_prdata1 = '0;
        if (m_resp) begin
            m_resp = 0; m_owner = -1; e_gnt = '0;
        end else if (m_owner < 0) begin
            if (psel_m0 || psel_m1) begin
                if (psel_m0 && psel_m1) m_owner = m_last ? 0 : 1;
                else                    m_owner = psel_m0 ? 0 : 1;
                m_last   = (m_owner == 1);
                e_psel   = 1; e_penable = 0;
                e_pwrite = m_owner ? pwrite_m1 : pwrite_m0;
                e_pstrb  = m_owner ? pstrb_m1  : pstrb_m0;
                e_paddr  = m_owner ? paddr_m1  : paddr_m0;
                e_pwdata = m_owner ? pwdata_m1 : pwdata_m0;
                e_gnt    = m_owner ? 2'b10 : 2'b01;
                m_age = 1; m_wait = 0;
            end
        end else if (m_age == 1) begin
            m_age = 2; e_penable = 1;
        end else if (pready) begin
            model_finish(prdata, pslverr);
        end else begin
            m_wait++;
            if (TIMEOUT_ON && m_wait == TO) model_finish('0, 1'b1);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        check("ctrl", {psel, penable, pwrite, pstrb, gnt, pready_m0, pready_m1, pslverr_m0, pslverr_m1},
              {e_psel, e_penable, e_pwrite, e_pstrb, e_gnt, e_pready0, e_pready1, e_err0, e_err1});
        check("paddr", paddr, e_paddr);
        check("pwdata", pwdata, e_pwdata);
        check("prdata_m0", prdata_m0, e_prdata0);
        check("prdata_m1", prdata_m1, e_prdata1);
    end

    // ---------------- grant order / pulse monitors ----------------
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    logic [1:0] prev_gnt = 2'b00;
    int         cnt_p0 = 0, cnt_p1 = 0;

    always @(negedge clk) begin
        if (gnt != 2'b00 && prev_gnt == 2'b00) obs_q.push_back(gnt);
        prev_gnt = gnt;
        if (pready_m0) cnt_p0++;
        if (pready_m1) cnt_p1++;
    end

    // ---------------- driver tasks ----------------
    logic          hist_psel[0:15], hist_pen[0:15];
    logic [1:0]    hist_gnt[0:15];
    logic [AW-1:0] hist_paddr[0:15];
    logic [DW-1:0] rd;
    logic          er;
    int            lat;

    task automatic drive_req(input int m, input logic sel, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (m == 0) begin
            psel_m0 = sel; penable_m0 = sel; pwrite_m0 = w; paddr_m0 = a; pwdata_m0 = d; pstrb_m0 = s;
        end else begin
            psel_m1 = sel; penable_m1 = sel; pwrite_m1 = w; paddr_m1 = a; pwdata_m1 = d; pstrb_m1 = s;
        end
    endtask

    task automatic wait_resp(input int m, output logic [DW-1:0] r, output logic e, output int l);
        l = 0; r = '0; e = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i < 16) begin
                hist_psel[i] = psel; hist_pen[i] = penable; hist_gnt[i] = gnt; hist_paddr[i] = paddr;
            end
            if ((m == 0 && pready_m0) || (m == 1 && pready_m1)) begin
                l = i;
                r = (m == 0) ? prdata_m0 : prdata_m1;
                e = (m == 0) ? pslverr_m0 : pslverr_m1;
                break;
            end
        end
        check("pready_seen", (l != 0), 1'b1);
    endtask

    task automatic xfer(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output logic [DW-1:0] r, output logic e, output int l);
        drive_req(m, 1'b1, w, a, d, s);
        wait_resp(m, r, e, l);
        @(posedge clk);
        #1;
        drive_req(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic stream(input int m, input int n);
        logic [DW-1:0] r;
        logic e;
        int l;
        for (int k = 0; k < n; k++)
            xfer(m, (m == 0), AW'(20'h00100 + 20'(m * 16'h100) + 20'(k)), DW'(16'h1000 + 16'(k)),
                 2'b01, r, e, l);
    endtask

    // ---------------- directed stimulus ----------------
    int p0_before, p1_before;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_psel", psel, 1'b0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_pready", {pready_m0, pready_m1, pslverr_m0, pslverr_m1}, 4'b0000);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // m0 write with pready tied high (also high during SETUP, which must be ignored)
        ds_tie1 = 1; ds_rdata = 16'h5A5A;
        xfer(0, 1'b1, 20'h00C1A, 16'hA007, 2'b11, rd, er, lat);
        check("t1_latency", lat, 4);
        check("t1_psel_idle", hist_psel[1], 1'b0);
        check("t1_psel_setup", {hist_psel[2], hist_pen[2]}, 2'b10);
        check("t1_penable_access", {hist_psel[3], hist_pen[3]}, 2'b11);
        check("t1_gnt", hist_gnt[2], 2'b01);
        check("t1_paddr", hist_paddr[2], 20'h00C1A);
        check("t1_err", er, 1'b0);
        check("t1_wr_capture", rd, 16'h5A5A);
        ds_tie1 = 0;

        // m1 read, three wait cycles
        ds_wait = 3; ds_rdata = 16'h1234;
        p0_before = cnt_p0;
        xfer(1, 1'b0, 20'h00010, 16'h0000, 2'b00, rd, er, lat);
        check("t2_latency", lat, 7);
        check("t2_rdata", rd, 16'h1234);
        check("t2_gnt", hist_gnt[3], 2'b10);
        @(negedge clk);
        check("t2_pulse_len", {pready_m1, prdata_m1}, 17'h0);
        check("t2_m0_quiet", cnt_p0, p0_before);
        @(posedge clk); #1;

        // continuous contention: strict alternation starting with m0
        ds_wait = 1; ds_rdata = 16'h0F0F;
        obs_q.delete();
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        fork
            stream(0, 3);
            stream(1, 3);
        join
        check("t3_grant_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("t3_grant_order", (i < obs_q.size()) ? obs_q[i] : 2'b11, exp_q[i]);

        // downstream error on m0, then a clean transfer
        ds_wait = 0; ds_err = 1; ds_rdata = 16'h0BAD;
        xfer(0, 1'b1, 20'h00020, 16'h5555, 2'b10, rd, er, lat);
        check("t4_err", er, 1'b1);
        ds_err = 0; ds_rdata = 16'hBEEF;
        xfer(0, 1'b0, 20'h00022, 16'h0000, 2'b00, rd, er, lat);
        check("t4_err_clear", er, 1'b0);
        check("t4_rdata", rd, 16'hBEEF);

        // reset during ACCESS of an m1 transfer
        ds_wait = 6; ds_rdata = 16'h7777;
        p1_before = cnt_p1;
        drive_req(1, 1'b1, 1'b0, 20'h00ABC, 16'h0000, 2'b00);
        @(posedge clk); @(posedge clk); #3;
        check("t5_in_access", {psel, penable, gnt}, 4'b1110);
        reset_n = 1'b0;
        #1;
        check("t5_async_drop", {psel, penable, gnt}, 4'b0000);
        obs_q.delete();
        ds_wait = 0; ds_rdata = 16'h0001;
        drive_req(0, 1'b1, 1'b1, 20'h00030, 16'hC0DE, 2'b11);
        @(posedge clk); @(negedge clk);
        check("t5_no_pready_m1", cnt_p1, p1_before);
        reset_n = 1'b1;
        wait_resp(0, rd, er, lat);
        check("t5_first_grant", (obs_q.size() > 0) ? obs_q[0] : 2'b00, 2'b01);
        check("t5_m0_latency", lat, 3);
        check("t5_m1_still_quiet", cnt_p1, p1_before);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, '0, '0, '0);
        wait_resp(1, rd, er, lat);
        check("t5_m1_served", rd, 16'h0001);
        @(posedge clk); #1;
        drive_req(1, 1'b0, 1'b0, '0, '0, '0);

`ifdef ARB_TIMEOUT_EN
        // downstream never ready: abort after TO ACCESS cycles
        ds_hang = 1; ds_rdata = 16'hFFFF;
        @(posedge clk); #1;
        xfer(0, 1'b0, 20'h00040, 16'h0000, 2'b00, rd, er, lat);
        check("t6_tmo_latency", lat, 3 + TO);
        check("t6_tmo_err", er, 1'b1);
        check("t6_tmo_rdata", rd, 16'h0000);
        ds_hang = 0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
